// File: rtl/wall_hit_monitor.sv
// Cube/wall collision monitor: accumulates per-wall overlap across a frame,
// debounces it over several frames and runs the IDLE/ARMED/CRASHED game state.
module wall_hit_monitor #(
  parameter int NWALLS       = 8,
  parameter int HIT_FRAMES   = 2,
  parameter int FLASH_FRAMES = 16,
  localparam int CW_W        = (NWALLS > 1) ? $clog2(NWALLS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame,
  input  logic              pixel_valid,
  input  logic [NWALLS-1:0] wall_px,
  input  logic              cube_px,
  input  logic              start,
  output logic              run,
  output logic              flash,
  output logic              crash,
  output logic [CW_W-1:0]   crash_wall,
  output logic [15:0]       survive
);

  typedef enum logic [1:0] {IDLE, ARMED, CRASHED} state_t;

  localparam logic [3:0] HIT4   = 4'(HIT_FRAMES);
  localparam logic [7:0] FLASH8 = 8'(FLASH_FRAMES - 1);

  state_t            r_state, w_state_nxt;
  logic [NWALLS-1:0] r_hit_acc;
  logic [3:0]        r_streak [NWALLS];
  logic [7:0]        r_fcnt;
  logic              r_run, r_flash, r_crash;
  logic [CW_W-1:0]   r_cw;
  logic [15:0]       r_survive;

  logic [NWALLS-1:0] w_sample;
  logic [3:0]        w_streak_nxt [NWALLS];
  logic              w_hit;
  logic [CW_W-1:0]   w_hit_idx;
  logic              w_start_run;

  // Streak update and lowest-index hit search; descending scan lets the
  // lowest wall index win when several walls reach the threshold together.
  always_comb begin
    w_sample  = pixel_valid ? (wall_px & {NWALLS{cube_px}}) : '0;
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int w = NWALLS - 1; w >= 0; w--) begin
      if (r_hit_acc[w])
        w_streak_nxt[w] = (r_streak[w] >= HIT4) ? HIT4 : r_streak[w] + 4'd1;
      else
        w_streak_nxt[w] = 4'd0;
      if (w_streak_nxt[w] == HIT4) begin
        w_hit     = 1'b1;
        w_hit_idx = CW_W'(w);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_run = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_state_nxt = ARMED;
        w_start_run = 1'b1;
      end
      ARMED: if (frame && w_hit) w_state_nxt = CRASHED;
      CRASHED: if (start) begin
        w_state_nxt = ARMED;
        w_start_run = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_run     <= 1'b0;
      r_crash   <= 1'b0;
      r_flash   <= 1'b1;
      r_fcnt    <= '0;
      r_cw      <= '0;
      r_survive <= '0;
      r_hit_acc <= '0;
      for (int w = 0; w < NWALLS; w++) r_streak[w] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= (w_state_nxt == ARMED);
      r_crash <= (w_state_nxt == CRASHED);
      if (w_start_run) begin
        // A start (even coinciding with a frame pulse) begins a fresh run.
        r_hit_acc <= '0;
        r_survive <= '0;
        r_flash   <= 1'b1;
        r_fcnt    <= '0;
        r_cw      <= '0;
        for (int w = 0; w < NWALLS; w++) r_streak[w] <= '0;
      end else begin
        if (frame) begin
          r_hit_acc <= w_sample;
          for (int w = 0; w < NWALLS; w++) r_streak[w] <= w_streak_nxt[w];
        end else begin
          r_hit_acc <= r_hit_acc | w_sample;
        end
        case (r_state)
          ARMED: if (frame) begin
            if (w_hit) begin
              r_cw    <= w_hit_idx;
              r_fcnt  <= '0;
              r_flash <= 1'b0;
            end else if (r_survive != 16'hFFFF) begin
              r_survive <= r_survive + 16'd1;
            end
          end
          CRASHED: if (frame) begin
            if (r_fcnt == FLASH8) begin
              r_flash <= ~r_flash;
              r_fcnt  <= '0;
            end else begin
              r_fcnt <= r_fcnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign run        = r_run;
  assign flash      = r_flash;
  assign crash      = r_crash;
  assign crash_wall = r_cw;
  assign survive    = r_survive;

endmodule

// File: doc/wall_hit_monitor.md
Name: wall_hit_monitor

Overview:
- Consumer side of the wall pixel interface: each wall block drives a per-pixel "wall here" signal; this block reads those signals together with the cube pixel during the VGA scan.
- Detects cube/wall overlap and debounces it across frames, so a hit must persist for several frames before a crash is declared.
- Runs the game run/crash state, counts frames survived, and generates the flash and run controls that go back to the wall blocks.
- Sits between the wall/cube pixel generators and the top-level game control.

Parameters:
- NWALLS, 8, number of wall pixel inputs.
- HIT_FRAMES, 2, consecutive frames with overlap needed to declare a crash (1..15).
- FLASH_FRAMES, 16, frames per flash half-period while crashed (1..255).

Ports:
- clk  input  1  pixel clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- frame  input  1  one-clk pulse marking end of active frame.
- pixel_valid  input  1  high while the scan is inside the active area.
- wall_px  input  NWALLS  bit w high when wall w covers the current pixel.
- cube_px  input  1  high when the cube covers the current pixel.
- start  input  1  one-clk pulse (start button, already debounced).
- run  output  1  high in ARMED; drives wall motion enable.
- flash  output  1  blink control for the wall blocks.
- crash  output  1  high in CRASHED.
- crash_wall  output  clog2(NWALLS)  index of the wall that caused the crash.
- survive  output  16  frames survived in the current run.

Behaviour:
- FSM states: IDLE, ARMED, CRASHED.
- Reset values: state=IDLE, run=0, flash=1, crash=0, crash_wall=0, survive=0. All hit_acc bits, streak counters and the flash counter are cleared.
- Overlap accumulation: on each clk with pixel_valid=1, hit_acc[w] |= wall_px[w] & cube_px. Samples taken while pixel_valid=0 are ignored.
- Frame cycle (frame=1):
  - For each w, streak[w] = hit_acc[w] ? min(streak[w]+1, HIT_FRAMES) : 0.
  - hit_acc is then cleared, but the overlap sample from this same cycle is kept in the new hit_acc. It counts toward the next frame, not the one just closed.
- IDLE:
  - run=0, flash=1, survive holds.
  - start → ARMED. On that transition, streak, hit_acc and survive clear to 0.
- ARMED:
  - run=1.
  - Each frame pulse increments survive, saturating at 16'hFFFF.
  - Crash condition: any streak[w] reaches HIT_FRAMES, evaluated on the frame-updated values.
  - If the crash condition holds in the same cycle as the frame pulse, the next state is CRASHED and:
    - crash_wall = lowest such index;
    - survive does NOT increment on that frame;
    - flash counter clears and flash is set to 0.
  - A start pulse in ARMED is ignored.
- CRASHED:
  - crash=1, run=0.
  - Overlap accumulation and streak updates continue, but do not change crash_wall.
  - Each frame increments the flash counter. When the counter reaches FLASH_FRAMES-1, flash toggles and the counter clears.
  - start → ARMED with the same clears as from IDLE, plus crash_wall=0 and flash=1.
- Output timing:
  - All outputs are registered and update one clk after the causing edge.
  - crash asserts on the clk after the decisive frame pulse.
- Simultaneous events:
  - start and frame in the same cycle while in IDLE/CRASHED: start wins. Counters clear, and that frame does not increment survive.
  - reset overrides everything, including mid-frame or mid-crash.
- Width rules:
  - Streak counters are 4 bits and saturate at HIT_FRAMES.
  - The flash counter is 8 bits.
  - crash_wall width is clog2(NWALLS), with a minimum of 1.

Test Plan:
- Reset → start pulse → 100 frame pulses with no overlap → run=1, crash=0, survive=100, flash=1.
- Overlap on wall 3 for one frame only, then clear frames → streak returns to 0, no crash, survive keeps counting.
- Overlap on walls 5 and 2 for 2 consecutive frames → crash=1 one clk after the 2nd frame pulse, crash_wall=2, run=0, survive frozen.
- While CRASHED, 32 frame pulses with FLASH_FRAMES=16 → flash starts at 0 and toggles after frames 16 and 32. Then a start pulse → ARMED, survive=0, crash=0, flash=1.
- Overlap asserted only while pixel_valid=0 for 5 frames → no crash.
- survive preloaded near saturation (65540 frames), and start asserted in the same cycle as frame while CRASHED:
  - survive saturates at 65535;
  - the start+frame cycle leaves survive=0 and state=ARMED.
- Reset asserted mid-frame while in CRASHED → next clk all outputs at their reset values.
